// File: rtl/snn_lif_layer.sv
// Layer of N_OUT leaky integrate-and-fire neurons, fully connected to N_IN spike lines.
// Latency: spike_o/spike_valid 1 cycle after step; pot_o is a 1-cycle registered read.
// No backpressure: a step is accepted every cycle it is asserted, weight writes always land.
module snn_lif_layer #(
  parameter int N_IN       = 8,
  parameter int N_OUT      = 2,
  parameter int W_POT      = 8,
  parameter int W_WGT      = 4,
  parameter int THRESH     = 64,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2,
  localparam int N_W       = N_IN * N_OUT,
  localparam int AW        = (N_W > 1) ? $clog2(N_W) : 1,
  localparam int SW        = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic [N_IN-1:0]    in_spikes,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [W_WGT-1:0]   wr_data,
  input  logic [SW-1:0]      rd_sel,
  output logic [N_OUT-1:0]   spike_o,
  output logic               spike_valid,
  output logic [W_POT-1:0]   pot_o
);

  // Synaptic sum width, then extra guard bits so V - leak + sum never wraps.
  localparam int WS = W_WGT + $clog2(N_IN) + 1;
  localparam int WN = W_POT + WS + 2;
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic signed [WN-1:0] VMAX    = signed'({{(WN-W_POT){1'b0}}, {W_POT{1'b1}}});
  localparam logic [AW:0]          N_W_C   = (AW+1)'(N_W);
  localparam logic [SW:0]          N_OUT_C = (SW+1)'(N_OUT);

  logic signed [W_WGT-1:0] wgt     [N_W];
  logic [W_POT-1:0]        pot     [N_OUT];
  logic [RW-1:0]           refrac  [N_OUT];
  logic signed [WN-1:0]    acc     [N_OUT];
  logic [W_POT-1:0]        nxt_pot [N_OUT];
  logic [N_OUT-1:0]        fire;

  // Candidate next potential per neuron: leak, integrate active synapses, saturate, threshold.
  always_comb begin
    for (int n = 0; n < N_OUT; n++) begin
      acc[n] = signed'({{(WN-W_POT){1'b0}}, pot[n]});
      if (LEAK_SHIFT > 0) begin
        acc[n] = acc[n] - signed'({{(WN-W_POT){1'b0}}, pot[n] >> LEAK_SHIFT});
      end
      for (int i = 0; i < N_IN; i++) begin
        if (in_spikes[i]) begin
          acc[n] = acc[n] + WN'(wgt[n*N_IN+i]);
        end
      end
      if (acc[n][WN-1]) begin
        nxt_pot[n] = '0;
      end else if (acc[n] > VMAX) begin
        nxt_pot[n] = '1;
      end else begin
        nxt_pot[n] = acc[n][W_POT-1:0];
      end
      fire[n] = (nxt_pot[n] >= W_POT'(THRESH));
    end
  end

  // Weight memory; a write coinciding with a step only affects later steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_W; k++) begin
        wgt[k] <= '0;
      end
    end else if (wr_en && ({1'b0, wr_addr} < N_W_C)) begin
      wgt[wr_addr] <= signed'(wr_data);
    end
  end

  // Neuron state and spike outputs advance together on each step pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_OUT; n++) begin
        pot[n]    <= '0;
        refrac[n] <= '0;
      end
      spike_o     <= '0;
      spike_valid <= 1'b0;
    end else begin
      spike_valid <= step;
      if (step) begin
        for (int n = 0; n < N_OUT; n++) begin
          if (refrac[n] != '0) begin
            refrac[n]  <= refrac[n] - RW'(1);
            spike_o[n] <= 1'b0;
          end else if (fire[n]) begin
            pot[n]     <= '0;
            refrac[n]  <= RW'(REFRAC);
            spike_o[n] <= 1'b1;
          end else begin
            pot[n]     <= nxt_pot[n];
            spike_o[n] <= 1'b0;
          end
        end
      end
    end
  end

  // Registered potential readback; out-of-range selects read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pot_o <= '0;
    end else if ({1'b0, rd_sel} < N_OUT_C) begin
      pot_o <= pot[rd_sel];
    end else begin
      pot_o <= '0;
    end
  end

endmodule

// File: tb/tb_snn_lif_layer.sv
// Directed bench for snn_lif_layer with a reference model checked every cycle.
module tb_snn_lif_layer;

  localparam int N_IN = 8, N_OUT = 2, W_POT = 8, W_WGT = 4;
  localparam int THRESH = 64, LEAK_SHIFT = 3, REFRAC = 2;
  localparam int VMAX = (1 << W_POT) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step = 1'b0;
  logic [7:0] in_spikes = '0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [0:0] rd_sel = '0;
  logic [1:0] spike_o;
  logic       spike_valid;
  logic [7:0] pot_o;

  int n_cmp = 0;
  int n_bad = 0;
  int vld_cnt = 0;

  // reference model state
  int         m_w [N_IN*N_OUT];
  int         m_v [N_OUT];
  int         m_r [N_OUT];
  logic [1:0] e_spk;
  logic       e_vld;
  int         e_pot;

  snn_lif_layer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .W_POT(W_POT), .W_WGT(W_WGT),
    .THRESH(THRESH), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .in_spikes(in_spikes),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_sel(rd_sel),
    .spike_o(spike_o), .spike_valid(spike_valid), .pot_o(pot_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int wsum(input int n);
    int s = 0;
    for (int i = 0; i < N_IN; i++)
      if (in_spikes[i]) s += m_w[n*N_IN+i];
    return s;
  endfunction

  function automatic int lif_next(input int v, input int s);
    int x;
    x = v - ((LEAK_SHIFT > 0) ? v / (1 << LEAK_SHIFT) : 0) + s;
    if (x < 0) x = 0;
    if (x > VMAX) x = VMAX;
    return x;
  endfunction

  // model: behaviour of one clock edge, cleared asynchronously by reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_IN*N_OUT; k++) m_w[k] <= 0;
      for (int n = 0; n < N_OUT; n++) begin
        m_v[n] <= 0;
        m_r[n] <= 0;
      end
      e_spk <= '0;
      e_vld <= 1'b0;
      e_pot <= 0;
    end else begin
      e_pot <= (int'(rd_sel) < N_OUT) ? m_v[rd_sel] : 0;
      e_vld <= step;
      if (wr_en && int'(wr_addr) < N_IN*N_OUT) m_w[wr_addr] <= int'($signed(wr_data));
      if (step) begin
        for (int n = 0; n < N_OUT; n++) begin
          if (m_r[n] > 0) begin
            m_r[n]   <= m_r[n] - 1;
            e_spk[n] <= 1'b0;
          end else if (lif_next(m_v[n], wsum(n)) >= THRESH) begin
            m_v[n]   <= 0;
            m_r[n]   <= REFRAC;
            e_spk[n] <= 1'b1;
          end else begin
            m_v[n]   <= lif_next(m_v[n], wsum(n));
            e_spk[n] <= 1'b0;
          end
        end
      end
    end
  end

  // per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    chk("spike_valid", int'(spike_valid), int'(e_vld));
    chk("spike_o", int'(spike_o), int'(e_spk));
    chk("pot_o", int'(pot_o), e_pot);
    if (spike_valid) vld_cnt++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 4'(a);
    wr_data = 4'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // returns at the negedge right after the step edge (spike outputs visible)
  task automatic do_step(input logic [7:0] sp);
    @(negedge clk);
    step = 1'b1;
    in_spikes = sp;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic run_steps(input int cnt);
    @(negedge clk);
    step = 1'b1;
    repeat (cnt) @(negedge clk);
    step = 1'b0;
  endtask

  int exp4 [12] = '{7, 14, 20, 25, 29, 33, 36, 39, 42, 44, 46, 48};

  initial begin
    // 1: reset state and zero-weight steps
    repeat (2) @(negedge clk);
    chk("rst_spike_o", int'(spike_o), 0);
    chk("rst_valid", int'(spike_valid), 0);
    chk("rst_pot", int'(pot_o), 0);
    rst_n = 1'b1;
    vld_cnt = 0;
    for (int k = 0; k < 5; k++) do_step(8'hFF);
    @(negedge clk);
    chk("t1_valid_pulses", vld_cnt, 5);
    chk("t1_pot", int'(pot_o), 0);

    // 2: neuron 0 all +7, fires on second step
    rd_sel = 1'b0;
    for (int k = 0; k < 8; k++) wr(k, 7);
    do_step(8'hFF);
    @(negedge clk);
    chk("t2_v0_after_T0", int'(pot_o), 56);
    chk("t2_model_v0", m_v[0], 56);
    do_step(8'hFF);
    chk("t2_spike_valid", int'(spike_valid), 1);
    chk("t2_spike_o", int'(spike_o), 1);
    @(negedge clk);
    chk("t2_v0_reset", int'(pot_o), 0);
    chk("t2_spike_hold", int'(spike_o), 1);

    // 3: two refractory steps, then integration resumes
    for (int k = 0; k < 2; k++) begin
      do_step(8'hFF);
      chk("t3_refrac_spike", int'(spike_o), 0);
      @(negedge clk);
      chk("t3_refrac_v0", int'(pot_o), 0);
    end
    do_step(8'hFF);
    chk("t3_resume_spike", int'(spike_o), 0);
    @(negedge clk);
    chk("t3_resume_v0", int'(pot_o), 56);

    // 4: neuron 1 single +7 synapse, back-to-back steps, leak-bounded
    do_reset();
    rd_sel = 1'b1;
    wr(8, 7);
    in_spikes = 8'h01;
    vld_cnt = 0;
    @(negedge clk);
    step = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j >= 2) chk("t4_v1_seq", int'(pot_o), exp4[j-2]);
    end
    step = 1'b0;
    @(negedge clk);
    chk("t4_v1_final", int'(pot_o), exp4[11]);
    chk("t4_valid_pulses", vld_cnt, 12);
    chk("t4_no_spike", int'(spike_o), 0);
    do_reset();
    wr(8, -8);
    in_spikes = 8'h01;
    run_steps(12);
    @(negedge clk);
    chk("t4_clamp_v1", int'(pot_o), 0);
    chk("t4_clamp_spike", int'(spike_o), 0);

    // 5: write and step in the same cycle
    do_reset();
    rd_sel = 1'b0;
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 4'd0;
    wr_data = 4'd7;
    step = 1'b1;
    in_spikes = 8'h01;
    @(negedge clk);
    wr_en = 1'b0;
    step = 1'b0;
    @(negedge clk);
    chk("t5_old_weight", int'(pot_o), 0);
    do_step(8'h01);
    @(negedge clk);
    chk("t5_new_weight", int'(pot_o), 7);

    // 6: asynchronous reset mid-run
    do_reset();
    for (int k = 8; k < 16; k++) wr(k, 7);
    do_step(8'hFF);
    do_step(8'hFF);
    chk("t6_n1_fire", int'(spike_o), 2);
    for (int k = 0; k < 8; k++) wr(k, 7);
    do_step(8'hFF);
    @(negedge clk);
    chk("t6_v0_pre", int'(pot_o), 56);
    chk("t6_model_r1", m_r[1], 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_pot", int'(pot_o), 0);
    chk("t6_async_spike", int'(spike_o), 0);
    chk("t6_async_valid", int'(spike_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_step(8'hFF);
    chk("t6_post_spike", int'(spike_o), 0);
    @(negedge clk);
    chk("t6_post_v0", int'(pot_o), 0);
    rd_sel = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_post_v1", int'(pot_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
